// File: rtl/edge_sync_pkg.sv
// rtl/edge_sync_pkg.sv - shared constants for the edge-synchronised capture block
// Holds filter length, default sizes and the FIFO pointer-width helper.
package edge_sync_pkg;

  localparam int FILTER_CYCLES = 3;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // One extra MSB beyond the address bits separates full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/edge_sync_fifo.sv
// rtl/edge_sync_fifo.sv - capture FIFO with registered head word and occupancy
// Pointers carry an extra wrap bit; the head register only moves when a word is present.
module edge_sync_fifo
  import edge_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [PW-1:0]    level
);

  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr, wptr_n, rptr_n;
  logic             empty, do_push, do_pop;
  logic [WIDTH-1:0] head_n;

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wptr_n  = wptr + {{(PW-1){1'b0}}, do_push};
  assign rptr_n  = rptr + {{(PW-1){1'b0}}, do_pop};

  // A word written this cycle into the slot about to become head bypasses the array.
  always_comb begin
    head_n = head;
    if (wptr_n != rptr_n) begin
      if (do_push && (wptr[AW-1:0] == rptr_n[AW-1:0])) head_n = push_data;
      else head_n = mem[rptr_n[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      head  <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      valid <= (wptr_n != rptr_n);
      head  <= head_n;
    end
  end

endmodule

// File: rtl/edge_sync_capture.sv
// rtl/edge_sync_capture.sv - captures d_in on rising edges of an asynchronous strobe
// Optional glitch filter on the strobe: EDGE_SYNC_CAPTURE_FILTER_EN.
module edge_sync_capture
  import edge_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   MasterClock,
  input  logic                   reset,
  input  logic                   clk_in,
  input  logic [WIDTH-1:0]       d_in,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] level
);

  logic             s0, s1, s2;
  logic [WIDTH-1:0] d0, d1;
  logic             rise, pop, full, drop;

  // The strobe chain is never reset so a strobe held high across reset cannot fake a rise.
  always_ff @(posedge MasterClock) begin
    s0 <= clk_in;
    s1 <= s0;
    s2 <= s1;
  end

  always_ff @(posedge MasterClock) begin
    if (reset) begin
      d0 <= '0;
      d1 <= '0;
    end else begin
      d0 <= d_in;
      d1 <= d0;
    end
  end

`ifdef EDGE_SYNC_CAPTURE_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(FILTER_CYCLES);

  logic [CW-1:0] high_cnt;

  // Reset parks the counter at saturation: only a fresh low-to-high run can fire.
  always_ff @(posedge MasterClock) begin
    if (reset) high_cnt <= CNT_SAT;
    else if (!s1) high_cnt <= '0;
    else if (high_cnt != CNT_SAT) high_cnt <= high_cnt + 1'b1;
  end

  assign rise = s1 && (high_cnt == CW'(FILTER_CYCLES - 1));
`else
  assign rise = s1 && !s2;
`endif

  assign pop  = out_valid && out_ready;
  assign drop = rise && full && !pop;

  always_ff @(posedge MasterClock) begin
    if (reset) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  edge_sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (MasterClock),
    .reset    (reset),
    .push     (rise),
    .push_data(d1),
    .pop      (pop),
    .full     (full),
    .valid    (out_valid),
    .head     (out_data),
    .level    (level)
  );

endmodule

// File: tb/tb_edge_sync_capture.sv
// tb/tb_edge_sync_capture.sv - bench for edge_sync_capture against a queue-based model
// Model: a rise is F consecutive high strobe samples after a low, landing two cycles later.
module tb_edge_sync_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef EDGE_SYNC_CAPTURE_FILTER_EN
  localparam int F = 3;
`else
  localparam int F = 1;
`endif

  logic             MasterClock = 1'b0;
  logic             reset = 1'b1;
  logic             clk_in = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic             out_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             out_valid, overflow;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       level;

  edge_sync_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .MasterClock(MasterClock),
    .reset      (reset),
    .clk_in     (clk_in),
    .d_in       (d_in),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .level      (level)
  );

  always #5 MasterClock = ~MasterClock;

  int vectors = 0;
  int miscompares = 0;

  bit               ch[$];
  logic [WIDTH-1:0] dh[$];
  logic [WIDTH-1:0] q[$];
  bit               m_ovf = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  int               e = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rise_at(input int k);
    int b = k - 2;
    if (b - F < 0) return 1'b0;
    if (ch[b-F]) return 1'b0;
    for (int j = 0; j < F; j++) if (!ch[b-j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step(input bit c, input logic [WIDTH-1:0] d, input bit rdy, input bit clr,
                      input bit rst);
    bit p, u, drp;
    clk_in = c; d_in = d; out_ready = rdy; ovf_clr = clr; reset = rst;
    ch.push_back(c);
    dh.push_back(d);
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_data = '0;
    end else begin
      p   = (q.size() > 0) && rdy;
      u   = rise_at(e);
      drp = u && (q.size() == DEPTH) && !p;
      if (p) void'(q.pop_front());
      if (u && !drp) q.push_back(dh[e-2]);
      if (drp) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (q.size() > 0) m_data = q[0];
    end
    e++;
    @(posedge MasterClock);
    @(negedge MasterClock);
    check_val("out_valid", out_valid, q.size() > 0);
    check_val("out_data", out_data, m_data);
    check_val("level", level, q.size());
    check_val("overflow", overflow, m_ovf);
  endtask

  // The word lands on the last high step; pop/clear can be aimed at that step.
  task automatic pulse(input logic [WIDTH-1:0] d, input int pop_at, input int clr_at);
    for (int i = 0; i < F + 1; i++) step(1'b0, d, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < F + 2; i++) step(1'b1, d, i == pop_at, i == clr_at, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] exp3 [4];
    int lvl_before;
    exp3 = '{8'h11, 8'h12, 8'h13, 8'h20};
    @(negedge MasterClock);
    repeat (6) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("reset_valid", out_valid, 1'b0);
    check_val("reset_level", level, 3'd0);

    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < F + 1; i++) step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_val("single_early", out_valid, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_val("single_valid", out_valid, 1'b1);
    check_val("single_data", out_data, 8'hA5);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("single_pop", out_valid, 1'b0);

    for (int k = 1; k <= 5; k++) pulse(8'(k), -1, -1);
    check_val("burst_level", level, 3'd4);
    check_val("burst_ovf", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_val("burst_order", out_data, 8'(i + 1));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    check_val("burst_drained", out_valid, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check_val("ovf_cleared", overflow, 1'b0);

    for (int k = 0; k < 4; k++) pulse(8'(8'h10 + k), -1, -1);
    pulse(8'h20, F + 1, -1);
    check_val("pushpop_level", level, 3'd4);
    check_val("pushpop_ovf", overflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_val("pushpop_order", out_data, exp3[i]);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    for (int k = 0; k < 4; k++) pulse(8'(8'h30 + k), -1, -1);
    pulse(8'h77, -1, F + 1);
    check_val("clr_vs_drop", overflow, 1'b1);
    step(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("mid_level", level, 3'd3);
    repeat (2) step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("rst_level", level, 3'd0);
    check_val("rst_valid", out_valid, 1'b0);
    check_val("rst_ovf", overflow, 1'b0);
    repeat (8) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_val("held_high_no_capture", level, 3'd0);

    lvl_before = int'(level);
    for (int i = 0; i < F + 2; i++) step(1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b0, 8'h66, 1'b0, 1'b0, 1'b0);
    check_val("short_pulse", level, 3'(lvl_before + ((F == 1) ? 1 : 0)));

    for (int s = 0; s < 500; s++) begin
      bit lv;
      int len;
      lv = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        len = 2 * F + 10;
        for (int i = 0; i < len; i++)
          step(lv, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, (i >= F + 4) && (i < F + 6));
      end else begin
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++)
          step(lv, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
